// File: rtl/cover_hit_scheduler.sv
// Sticky toggle-coverage recorder that queues first hits and drains them one index per transfer.
// Optional macro COVER_CLEAR_EN adds a clear input that restarts coverage collection.
module cover_hit_scheduler #(
    parameter int WIDTH       = 17,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
`ifdef COVER_CLEAR_EN
    input  logic                         clear,
`endif
    input  logic [WIDTH-1:0]             valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         all_covered,
    output logic                         pending_any
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] pending;
    logic [PTR_W-1:0] ptr;

    logic [WIDTH-1:0] base_cov;
    logic [WIDTH-1:0] base_pend;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] sel_mask;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    logic             load;
    logic             take;
    logic             clr;

    // Round-robin search: lowest rotation offset from start wins, so scan offsets downward.
    function automatic logic [PTR_W:0] rr_pick(input logic [WIDTH-1:0] pend,
                                               input logic [PTR_W-1:0] start);
        logic [PTR_W:0] r;
        int             p;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            p = int'(start) + i;
            if (p >= WIDTH) p = p - WIDTH;
            if (pend[p]) r = {1'b1, PTR_W'(p)};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

`ifdef COVER_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        {found, sel} = rr_pick(pending, ptr);
        load      = !out_valid || out_ready;
        // A clear discards pending work, so nothing new is launched in that cycle.
        take      = load && found && !clr;
        sel_mask  = take ? (WIDTH'(1) << sel) : '0;
        base_cov  = clr ? '0 : covered;
        base_pend = clr ? '0 : pending;
        base_cnt  = clr ? '0 : covered_count;
        new_hits  = en ? (valid & ~base_cov) : '0;
        ptr_next  = (int'(sel) == WIDTH - 1) ? '0 : sel + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            covered       <= '0;
            pending       <= '0;
            ptr           <= '0;
            covered_count <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
        end else begin
            covered       <= base_cov | new_hits;
            pending       <= (base_pend & ~sel_mask) | new_hits;
            covered_count <= base_cnt + popcount(new_hits);
            if (load) begin
                out_valid <= take;
                if (take) begin
                    out_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
                    ptr       <= ptr_next;
                end
            end
        end
    end

    assign all_covered = (covered_count == CNT_W'(WIDTH));
    assign pending_any = |pending;

endmodule

// File: tb/tb_cover_hit_scheduler.sv
// Scoreboard bench for cover_hit_scheduler: expected indices are queued as hits are driven
// and popped on every accepted transfer.
module tb_cover_hit_scheduler;

    localparam int W  = 17;
    localparam int CI = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  valid = '0;
    logic          out_valid;
    logic [31:0]   out_index;
    logic [4:0]    covered_count;
    logic          all_covered;
    logic          pending_any;
`ifdef COVER_CLEAR_EN
    logic          clear = 1'b0;
`endif

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_emit = 0;
    int unsigned   exp_q[$];

    cover_hit_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .IDX_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
`ifdef COVER_CLEAR_EN
        .clear         (clear),
`endif
        .valid         (valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered),
        .pending_any   (pending_any)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Transfers happen at the next rising edge; sample them mid-cycle.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            n_emit++;
            if (exp_q.size() == 0) check("extra_emit", {31'b0, out_valid}, 32'd0);
            else check("emit_index", out_index, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid && !pending_any) break;
            tick();
        end
        check(tag, exp_q.size(), 0);
        check({tag, "_idle"}, {31'b0, out_valid | pending_any}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all hits asserted
        en = 1'b1; out_ready = 1'b1; valid = '1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1; valid = '0;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_count", {27'b0, covered_count}, 0);
        check("rst_all", {31'b0, all_covered}, 0);
        check("rst_pending", {31'b0, pending_any}, 0);
        check("rst_index", out_index, 0);

        // Single hit latency
        valid = 17'h00004;
        tick();
        valid = '0;
        exp_q.push_back(CI + 2);
        check("lat_k_valid", {31'b0, out_valid}, 0);
        check("lat_k_pending", {31'b0, pending_any}, 1);
        check("lat_k_count", {27'b0, covered_count}, 1);
        tick();
        check("lat_k1_valid", {31'b0, out_valid}, 1);
        check("lat_k1_index", out_index, CI + 2);
        tick();
        check("lat_k2_valid", {31'b0, out_valid}, 0);
        valid = 17'h00004;
        tick();
        valid = '0;
        repeat (4) tick();
        check("repeat_count", {27'b0, covered_count}, 1);
        check("repeat_valid", {31'b0, out_valid}, 0);
        drain("drain1");

        // Three hits, pointer sits at 3 so 16 wraps ahead of 0 and 1
        valid = 17'h10003;
        tick();
        valid = '0;
        exp_q.push_back(CI + 16); exp_q.push_back(CI + 0); exp_q.push_back(CI + 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_valid", {31'b0, out_valid}, 1);
        end
        tick();
        check("b2b_end", {31'b0, out_valid}, 0);
        check("b2b_count", {27'b0, covered_count}, 4);
        drain("drain2");

        // Backpressure holds the output register
        out_ready = 1'b0;
        valid = 17'h00008;
        tick();
        valid = 17'h00020;
        exp_q.push_back(CI + 3); exp_q.push_back(CI + 5);
        tick();
        valid = '0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_index", out_index, CI + 3);
            check("hold_pending", {31'b0, pending_any}, 1);
            tick();
        end
        out_ready = 1'b1;
        drain("drain3");
        check("bp_count", {27'b0, covered_count}, 6);

        // Disabled sampling
        en = 1'b0; valid = 17'h00040;
        tick(); tick();
        valid = '0; en = 1'b1;
        check("en0_count", {27'b0, covered_count}, 6);
        check("en0_pending", {31'b0, pending_any}, 0);

        // Pointer at 6: 8 comes before 4
        valid = 17'h00110;
        tick();
        valid = '0;
        exp_q.push_back(CI + 8); exp_q.push_back(CI + 4);
        drain("drain4");
        check("pre_all", {31'b0, all_covered}, 0);

        // Remaining points all at once, pointer at 5
        valid = '1;
        tick();
        valid = '0;
        check("all_cov", {31'b0, all_covered}, 1);
        check("all_count", {27'b0, covered_count}, W);
        exp_q.push_back(CI + 6); exp_q.push_back(CI + 7);
        for (int b = 9; b <= 15; b++) exp_q.push_back(CI + b);
        drain("drain5");
        check("total_emits", n_emit, W);
        check("all_sticky", {31'b0, all_covered}, 1);

        // Reset while a transfer is pending
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst2_count", {27'b0, covered_count}, 0);
        out_ready = 1'b0;
        valid = 17'h00001;
        tick();
        valid = '0;
        tick();
        check("mid_valid", {31'b0, out_valid}, 1);
        check("mid_index", out_index, CI);
        reset = 1'b0;
        tick();
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_count", {27'b0, covered_count}, 0);
        check("mid_rst_pending", {31'b0, pending_any}, 0);
        exp_q.delete();
        reset = 1'b1; out_ready = 1'b1;

`ifdef COVER_CLEAR_EN
        valid = 17'h00080;
        tick();
        valid = '0;
        exp_q.push_back(CI + 7);
        drain("clr_drain1");
        clear = 1'b1; valid = 17'h00080;
        tick();
        clear = 1'b0; valid = '0;
        exp_q.push_back(CI + 7);
        check("clr_hit_count", {27'b0, covered_count}, 1);
        drain("clr_drain2");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", {27'b0, covered_count}, 0);
        check("clr_pending", {31'b0, pending_any}, 0);
        valid = 17'h00080;
        tick();
        valid = '0;
        exp_q.push_back(CI + 7);
        check("clr_rehit_count", {27'b0, covered_count}, 1);
        drain("clr_drain3");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
